// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: RV32I control for a non-forwarding 5-stage pipe.
// Decodes ID into ID/EX, resolves branches in EX, stalls on RAW.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   id_instr, id_vld         ID instruction and its valid bit
//   ex_br_less, ex_br_equal  comparator flags for the EX instruction
//   ex_*                     registered control word of the EX instruction
//   ex_br_sel, flush         PC redirect / IF-ID kill (combinational)
//   stall                    hold PC and IF/ID (combinational)
//   stall_cnt, flush_cnt     saturating event counters
module ctrl_pipe_unit #(
    parameter int NUM_HAZ_STAGES = 3,
    parameter int WB_BYPASS_RF   = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_vld,
    input  logic             ex_br_less,
    input  logic             ex_br_equal,
    output logic [3:0]       ex_alu_op,
    output logic             ex_op_a_sel,
    output logic             ex_op_b_sel,
    output logic             ex_br_unsigned,
    output logic             ex_rd_wren,
    output logic             ex_mem_wren,
    output logic             ex_mem_rden,
    output logic [1:0]       ex_wb_sel,
    output logic [2:0]       ex_l_length,
    output logic             ex_l_unsigned,
    output logic [1:0]       ex_s_length,
    output logic             ex_insn_vld,
    output logic [4:0]       ex_rd_addr,
    output logic             ex_br_sel,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_B     = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_JUMP = 2'd1,
        BR_COND = 2'd2
    } br_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       op_a_sel;
        logic       op_b_sel;
        logic       br_unsigned;
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic [1:0] wb_sel;
        logic [2:0] l_length;
        logic       l_unsigned;
        logic [1:0] s_length;
        logic       insn_vld;
        logic [4:0] rd_addr;
        br_t        br_type;
        logic [2:0] br_f3;
    } ctrl_t;

    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opc = id_instr[6:0];
    assign rd  = id_instr[11:7];
    assign f3  = id_instr[14:12];
    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];
    assign f7  = id_instr[31:25];

    logic is_r, is_i, is_ld, is_s, is_b;
    logic is_jal, is_jalr, is_lui, is_aui;

    assign is_r    = (opc == OP_R) && (f7 == 7'h00 || f7 == 7'h20);
    assign is_i    = (opc == OP_I);
    assign is_ld   = (opc == OP_LD);
    assign is_s    = (opc == OP_S);
    assign is_b    = (opc == OP_B);
    assign is_jal  = (opc == OP_JAL);
    assign is_jalr = (opc == OP_JALR);
    assign is_lui  = (opc == OP_LUI);
    assign is_aui  = (opc == OP_AUIPC);

    // alt picks SUB over ADD and SRA over SRL
    function automatic logic [3:0] alu_of(input logic [2:0] f,
                                          input logic alt);
        logic [3:0] op;
        unique case (f)
            3'b000: op = alt ? 4'd1 : 4'd0;
            3'b001: op = 4'd7;
            3'b010: op = 4'd2;
            3'b011: op = 4'd3;
            3'b100: op = 4'd4;
            3'b101: op = alt ? 4'd9 : 4'd8;
            3'b110: op = 4'd5;
            3'b111: op = 4'd6;
        endcase
        return op;
    endfunction

    ctrl_t dec;
    logic  use_rs1;
    logic  use_rs2;

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec.alu_op  = alu_of(f3, f7[5]);
                dec.rd_wren = 1'b1;
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
            end
            is_i: begin
                // bit 30 is immediate data except for SRAI
                dec.alu_op   = alu_of(f3, (f3 == 3'b101) && f7[5]);
                dec.op_b_sel = 1'b1;
                dec.rd_wren  = 1'b1;
                use_rs1      = 1'b1;
            end
            is_ld: begin
                dec.op_b_sel   = 1'b1;
                dec.rd_wren    = 1'b1;
                dec.mem_rden   = 1'b1;
                dec.wb_sel     = 2'b01;
                dec.l_length   = f3;
                dec.l_unsigned = (f3 == 3'b100) || (f3 == 3'b101);
                use_rs1        = 1'b1;
            end
            is_s: begin
                dec.op_b_sel = 1'b1;
                dec.mem_wren = 1'b1;
                dec.s_length = f3[1:0];
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            is_b: begin
                dec.op_a_sel    = 1'b1;
                dec.op_b_sel    = 1'b1;
                dec.br_unsigned = (f3[2:1] == 2'b11);
                dec.br_type     = BR_COND;
                dec.br_f3       = f3;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            is_jal: begin
                dec.op_a_sel = 1'b1;
                dec.op_b_sel = 1'b1;
                dec.rd_wren  = 1'b1;
                dec.wb_sel   = 2'b10;
                dec.br_type  = BR_JUMP;
            end
            is_jalr: begin
                dec.op_b_sel = 1'b1;
                dec.rd_wren  = 1'b1;
                dec.wb_sel   = 2'b10;
                dec.br_type  = BR_JUMP;
                use_rs1      = 1'b1;
            end
            is_lui: begin
                dec.alu_op   = 4'd10;
                dec.op_b_sel = 1'b1;
                dec.rd_wren  = 1'b1;
            end
            is_aui: begin
                dec.op_a_sel = 1'b1;
                dec.op_b_sel = 1'b1;
                dec.rd_wren  = 1'b1;
            end
            default: ;
        endcase
        dec.insn_vld = is_r | is_i | is_ld | is_s | is_b |
                       is_jal | is_jalr | is_lui | is_aui;
        dec.rd_addr  = dec.rd_wren ? rd : 5'd0;
    end

    ctrl_t ex_q;
    ctrl_t ld;

    always_comb begin
        ex_br_sel = 1'b0;
        case (ex_q.br_type)
            BR_JUMP: ex_br_sel = 1'b1;
            BR_COND: begin
                case (ex_q.br_f3)
                    3'b000:         ex_br_sel = ex_br_equal;
                    3'b001:         ex_br_sel = !ex_br_equal;
                    3'b100, 3'b110: ex_br_sel = ex_br_less;
                    3'b101, 3'b111: ex_br_sel = !ex_br_less;
                    default:        ex_br_sel = 1'b0;
                endcase
            end
            default: ex_br_sel = 1'b0;
        endcase
    end

    assign flush = ex_br_sel;

    // entry 0 = EX, last entry = WB
    logic [NUM_HAZ_STAGES-1:0] pnd_vld;
    logic [4:0]                pnd_rd [NUM_HAZ_STAGES];
    logic                      hazard;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < NUM_HAZ_STAGES - WB_BYPASS_RF; i++) begin
            if (pnd_vld[i]) begin
                if (use_rs1 && rs1 != 5'd0 && rs1 == pnd_rd[i])
                    hazard = 1'b1;
                if (use_rs2 && rs2 != 5'd0 && rs2 == pnd_rd[i])
                    hazard = 1'b1;
            end
        end
    end

    // a taken redirect makes the ID instruction wrong-path, so never stall on it
    assign stall = hazard && id_vld && !flush;
    assign ld    = (flush || stall || !id_vld) ? '0 : dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            pnd_vld <= '0;
            for (int i = 0; i < NUM_HAZ_STAGES; i++)
                pnd_rd[i] <= 5'd0;
        end else begin
            ex_q       <= ld;
            pnd_vld[0] <= ld.rd_wren && (ld.rd_addr != 5'd0);
            pnd_rd[0]  <= ld.rd_addr;
            for (int i = 1; i < NUM_HAZ_STAGES; i++) begin
                pnd_vld[i] <= pnd_vld[i-1];
                pnd_rd[i]  <= pnd_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign ex_alu_op      = ex_q.alu_op;
    assign ex_op_a_sel    = ex_q.op_a_sel;
    assign ex_op_b_sel    = ex_q.op_b_sel;
    assign ex_br_unsigned = ex_q.br_unsigned;
    assign ex_rd_wren     = ex_q.rd_wren;
    assign ex_mem_wren    = ex_q.mem_wren;
    assign ex_mem_rden    = ex_q.mem_rden;
    assign ex_wb_sel      = ex_q.wb_sel;
    assign ex_l_length    = ex_q.l_length;
    assign ex_l_unsigned  = ex_q.l_unsigned;
    assign ex_s_length    = ex_q.s_length;
    assign ex_insn_vld    = ex_q.insn_vld;
    assign ex_rd_addr     = ex_q.rd_addr;

endmodule
